multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Control FSM that sequences the processor datapath over several cycles: instruction fetch handshake, decode, execute, writeback/branch.
- Drives instruction-register load, PC update, register-file write enable and ALU operand select.
- Consumes opcode and illegal-instruction flag from the decode stage.
- Keeps retired-instruction and error counters for debug.

Parameters:
- CNT_W, 16, width of instr_count and err_count; both saturate at all-ones.
- FETCH_TIMEOUT, 8, max cycles in FETCH without imem_ready before entering HALT (range 1..255).
- HALT_ON_ERR, 1, 1: illegal instruction → HALT; 0: count it, skip it (PC+4), continue.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  leave IDLE and begin fetching; level-sampled in IDLE only.
- stop  in  1  return to IDLE after the current instruction retires.
- imem_req  out  1  instruction fetch request.
- imem_ready  in  1  instruction memory data valid this cycle.
- opcode  in  7  from decode (instr[6:0] of IR).
- hata  in  1  illegal-opcode flag from decode.
- branch_taken  in  1  branch compare result from ALU, valid in BRANCH.
- ir_we  out  1  load instruction register.
- pc_we  out  1  update PC.
- pc_sel  out  1  0: PC+4, 1: PC+imm.
- rf_we  out  1  register-file write enable (drives decode "we").
- alu_src_imm  out  1  ALU operand B = imm (1) or rs2_data (0).
- state  out  3  current state encoding.
- busy  out  1  state not IDLE and not HALT.
- halted  out  1  state == HALT.
- instr_count  out  CNT_W  retired instructions (R/I/U/B).
- err_count  out  CNT_W  illegal instructions seen.

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, BRANCH=5, HALT=6. Encoding 7 unused; if reached, go to HALT next cycle.
- Reset (reset=0, async):
  - state=IDLE; counters=0; internal class reg=0; timeout counter=0.
  - All strobes (imem_req, ir_we, pc_we, pc_sel, rf_we, alu_src_imm) = 0.
  - Reset mid-fetch or mid-instruction abandons it; no partial writes.
- Output style: Moore from state, except ir_we = (state==FETCH) & imem_ready. All strobes default 0.
- IDLE: start=1 → FETCH.
- FETCH:
  - imem_req=1.
  - imem_ready=1 → ir_we=1 that cycle, timeout clears, → DECODE.
  - Otherwise the timeout counter increments. Reaching FETCH_TIMEOUT consecutive not-ready cycles → HALT.
- DECODE (1 cycle):
  - Latch instruction class from opcode: R=0000001, I=0000011, U=0000111, B=0001111.
  - hata=1 → err_count++. Then HALT if HALT_ON_ERR=1; else pc_we=1, pc_sel=0, → FETCH (no instr_count increment).
  - B → BRANCH; R/I/U → EXEC.
- EXEC (1 cycle): alu_src_imm=1 for latched class I or U, 0 for R. → WB.
- WB:
  - rf_we=1, pc_we=1, pc_sel=0; alu_src_imm held as in EXEC; instr_count++.
  - stop=1 → IDLE, else → FETCH.
- BRANCH:
  - pc_we=1, pc_sel=branch_taken, rf_we=0, instr_count++.
  - stop=1 → IDLE, else → FETCH.
- HALT: all strobes 0, halted=1. Exits only via reset; start and stop are ignored.
- stop in FETCH/DECODE/EXEC has no effect until WB/BRANCH samples it. stop and start both high in IDLE → FETCH (start wins in IDLE).
- Latency: R/I/U retire in 4 cycles min (FETCH with immediate ready, DECODE, EXEC, WB); B in 3 cycles.
- Counters saturate at 2^CNT_W-1 and never wrap. A saturated err_count does not block the HALT_ON_ERR=0 skip path.

Test Plan:
- Reset, start=1, imem_ready=1 always, IR stream = R-type (0x00000001-class) ×3 → state sequence 1,2,3,4 repeating; rf_we high one cycle per 4; instr_count=3 after 12 cycles from FETCH entry; alu_src_imm=0.
- I-type then B-type with branch_taken=1 → I: alu_src_imm=1 in EXEC/WB, rf_we=1. B: BRANCH 1 cycle with pc_we=1, pc_sel=1, rf_we=0. instr_count=2.
- imem_ready low 7 cycles then high, FETCH_TIMEOUT=8 → no halt, ir_we pulses on cycle 8. Ready held low 8 cycles → HALT, halted=1, imem_req=0.
- Opcode 0x7F (hata=1), HALT_ON_ERR=1 → err_count=1, HALT after DECODE. With HALT_ON_ERR=0: pc_we=1, pc_sel=0 in DECODE, back to FETCH, instr_count unchanged.
- stop asserted during EXEC → WB completes (rf_we=1), then IDLE; busy=0; start again → FETCH.
- reset pulsed low during EXEC → immediately state=0, rf_we and pc_we never asserted, counters=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: sequences fetch, decode, execute and
// writeback/branch, and keeps debug counters for retired and illegal instructions.
module multicycle_ctrl #(
  parameter int CNT_W         = 16,
  parameter int FETCH_TIMEOUT = 8,
  parameter bit HALT_ON_ERR   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic [6:0]       opcode,
  input  logic             hata,
  input  logic             branch_taken,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             rf_we,
  output logic             alu_src_imm,
  output logic [2:0]       state,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_BRANCH = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [1:0] CLS_R = 2'd0;
  localparam logic [1:0] CLS_I = 2'd1;
  localparam logic [1:0] CLS_U = 2'd2;
  localparam logic [1:0] CLS_B = 2'd3;

  localparam logic [6:0] OP_R = 7'b0000001;
  localparam logic [6:0] OP_I = 7'b0000011;
  localparam logic [6:0] OP_U = 7'b0000111;
  localparam logic [6:0] OP_B = 7'b0001111;

  localparam logic [7:0]       TO_LAST = 8'(FETCH_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [2:0] next_state;
  logic [1:0] cls;
  logic [1:0] dec_cls;
  logic [7:0] tcnt;

  // Unrecognised opcodes without hata fall back to the R class.
  always_comb begin
    dec_cls = CLS_R;
    case (opcode)
      OP_R:    dec_cls = CLS_R;
      OP_I:    dec_cls = CLS_I;
      OP_U:    dec_cls = CLS_U;
      OP_B:    dec_cls = CLS_B;
      default: dec_cls = CLS_R;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_FETCH;
      S_FETCH: begin
        if (imem_ready)            next_state = S_DECODE;
        else if (tcnt == TO_LAST)  next_state = S_HALT;
      end
      S_DECODE: begin
        if (hata)                  next_state = HALT_ON_ERR ? S_HALT : S_FETCH;
        else if (dec_cls == CLS_B) next_state = S_BRANCH;
        else                       next_state = S_EXEC;
      end
      S_EXEC:   next_state = S_WB;
      S_WB,
      S_BRANCH: next_state = stop ? S_IDLE : S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_HALT;
    endcase
  end

  // Strobes are Moore decodes of state; ir_we and the illegal-skip pc_we also look at inputs.
  always_comb begin
    imem_req    = (state == S_FETCH);
    ir_we       = (state == S_FETCH) && imem_ready;
    rf_we       = (state == S_WB);
    pc_we       = (state == S_WB) || (state == S_BRANCH) ||
                  ((state == S_DECODE) && hata && !HALT_ON_ERR);
    pc_sel      = (state == S_BRANCH) && branch_taken;
    alu_src_imm = ((state == S_EXEC) || (state == S_WB)) &&
                  ((cls == CLS_I) || (cls == CLS_U));
    busy        = (state != S_IDLE) && (state != S_HALT);
    halted      = (state == S_HALT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cls         <= CLS_R;
      tcnt        <= 8'd0;
      instr_count <= '0;
      err_count   <= '0;
    end else begin
      state <= next_state;
      if (state == S_DECODE && !hata) cls <= dec_cls;
      if (state == S_FETCH && !imem_ready) tcnt <= tcnt + 8'd1;
      else                                 tcnt <= 8'd0;
      if ((state == S_WB || state == S_BRANCH) && instr_count != CNT_MAX)
        instr_count <= instr_count + CNT_W'(1);
      if (state == S_DECODE && hata && err_count != CNT_MAX)
        err_count <= err_count + CNT_W'(1);
    end
  end

endmodule
